coin_scheduler: RTL and testbench
=================================

# coin_scheduler

Sits between the four coin debouncers and the vending-machine FSM. It converts each debounced coin level into a single coin event and queues events per denomination. It then issues them to the FSM one at a time as single-cycle pulses, with a guaranteed quiet gap between issues. Simultaneous or bursty insertions are never merged or lost unless a queue saturates, and the FSM never sees more than one coin input high in the same cycle.

## Interface
- PEND_W, 3: width of each per-denomination pending counter; max queued per coin = 2^PEND_W-1.
- GAP_CYCLES, 2: idle cycles forced after every issued pulse (≥1).

Ports:
- CLK  in  1  system clock, rising edge. One clock; all logic is in this domain.
- RST  in  1  reset, synchronous, active-high.
- Enable  in  1  machine enable, same signal as the FSM's.
- OneDollarIn, FiftyCentsIn, TenCentsIn, FiveCentsIn  in  1 each  debounced coin levels.
- Deliver  in  1  FSM deliver indication; issuing pauses while high.
- OneDollar, FiftyCents, TenCents, FiveCents  out  1 each  coin pulses to the FSM, registered.
- Busy  out  1  high if any counter is non-zero or the state is not IDLE.
- Overflow  out  1  sticky; set when a coin edge arrives at a saturated counter.

## Operation
- Requester index: 0 = OneDollar, 1 = FiftyCents, 2 = TenCents, 3 = FiveCents.
- Edge detect:
  - Each input is registered (In_d) every cycle, regardless of Enable.
  - An event is In=1 and In_d=0, sampled on the same edge.
  - Events are counted only when Enable=1. Events while Enable=0 are dropped, with no Overflow.
- Pending counters, one per requester, PEND_W bits, unsigned:
  - Event → +1.
  - Issue of that requester → −1.
  - Event and issue on the same edge → unchanged.
  - Event at max with no same-edge issue → count stays at max, Overflow←1.
  - Counters never wrap.
- Round-robin pointer:
  - 2 bits, resets to 0.
  - Search starts at the pointer and proceeds index+1 mod 4. The first non-zero counter wins.
  - After a grant of i, pointer ← (i+1) mod 4.
- States: IDLE, ISSUE, GAP.
  - IDLE → ISSUE when Enable=1, Deliver=0 and any counter >0. The winner is latched.
  - In IDLE with Enable=0 or Deliver=1, the block stays in IDLE. Counters are held, except for new events when Enable=1.
  - ISSUE → GAP unconditionally after 1 cycle. The latched winner's output is high for exactly this cycle, and its counter is decremented on the edge that leaves ISSUE.
  - GAP → IDLE after GAP_CYCLES cycles in GAP, using an internal down-counter. All coin outputs are 0 in GAP.
- Enable or Deliver changing during ISSUE or GAP does not abort the sequence. The pulse in progress completes and the gap is honoured.
- At most one coin output is high in any cycle.
- Reset, including mid-ISSUE or mid-GAP: on the next edge the state goes to IDLE and all counters, the pointer, In_d, the gap counter, Overflow and all outputs go to 0.

## Timing
- Reset values: OneDollar = FiftyCents = TenCents = FiveCents = 0, Busy = 0, Overflow = 0.
- Latency, from an idle block: event sampled on edge k → counter = 1 after k → IDLE grants on k+1 → coin output high for the cycle between edges k+1 and k+2.
- Issue period: ISSUE (1 cycle) + GAP (GAP_CYCLES) + IDLE (1 cycle), so back-to-back pulses start GAP_CYCLES+2 cycles apart (4 at the default).
- Busy is combinational from registered state and counters. It is valid in the cycle after an event is counted and drops the cycle after the last GAP ends with all counters at 0.
- Overflow is registered and rises on the edge of the saturating event.
- The FSM sees each pulse for exactly one CLK cycle, never two in consecutive cycles.

## Test plan
- Reset/single coin:
  - Stimulus: RST for 2 cycles, then raise TenCentsIn at edge k and hold it high for 20 cycles.
  - Required: TenCents pulses once, in cycle k+1..k+2. Busy returns to 0 after the gap. No other output fires.
- Simultaneous insertion:
  - Stimulus: all four inputs rise on the same edge, pointer = 0.
  - Required: pulses in order OneDollar, FiftyCents, TenCents, FiveCents, 4 cycles apart. Each appears exactly once.
- Round-robin fairness:
  - Stimulus: queue 3 OneDollar and 3 FiveCents.
  - Required: issue order alternates OneDollar, FiveCents ×3. No output is ever high together with another.
- Saturation:
  - Stimulus: Deliver=1, then 8 FiftyCents edges with PEND_W=3, then Deliver=0.
  - Required: Overflow=1 after the 8th edge. Exactly 7 FiftyCents pulses are issued. Overflow stays 1 until RST.
- Enable/Deliver gating:
  - Stimulus: FiveCents edges while Enable=0.
  - Required: no pulse, counter stays 0, Overflow stays 0.
  - Stimulus: a queued coin with Deliver held high for 10 cycles.
  - Required: no pulse until the cycle after Deliver falls plus 1.
- Reset mid-operation:
  - Stimulus: assert RST during GAP with 2 coins pending.
  - Required: all outputs 0, Busy 0 after the next edge. No pulse follows once RST is released.

Source files
------------

// File: rtl/coin_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : coin_scheduler
// Purpose  : Turns debounced coin levels into queued coin events. Issues them
//            to the vending FSM one at a time, as gapped single-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module coin_scheduler #(
    parameter int PEND_W     = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic Enable,
    input  logic OneDollarIn,
    input  logic FiftyCentsIn,
    input  logic TenCentsIn,
    input  logic FiveCentsIn,
    input  logic Deliver,
    output logic OneDollar,
    output logic FiftyCents,
    output logic TenCents,
    output logic FiveCents,
    output logic Busy,
    output logic Overflow
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0]        c_stIdle  = 2'd0;
    localparam logic [1:0]        c_stIssue = 2'd1;
    localparam logic [1:0]        c_stGap   = 2'd2;
    localparam logic [GAP_W-1:0]  c_gapLoad = GAP_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] c_pendMax = '1;

    logic [3:0]             w_coinIn;
    logic [3:0]             w_event;
    logic [3:0]             w_pendNz;
    logic [3:0]             w_issue;
    logic [3:0]             w_sat;
    logic                   w_grant;
    logic                   w_found;
    logic [1:0]             w_winner;
    logic [1:0]             w_idx;

    logic [3:0]             r_inD;
    logic [3:0][PEND_W-1:0] r_pend;
    logic [1:0]             r_ptr;
    logic [1:0]             r_winner;
    logic [1:0]             r_state;
    logic [GAP_W-1:0]       r_gapCnt;
    logic [3:0]             r_coinOut;
    logic                   r_overflow;

    assign w_coinIn = {FiveCentsIn, TenCentsIn, FiftyCentsIn, OneDollarIn};
    assign w_event  = w_coinIn & ~r_inD & {4{Enable}};

    for (genvar gi = 0; gi < 4; gi++) begin : g_req
        assign w_pendNz[gi] = |r_pend[gi];
        assign w_issue[gi]  = (r_state == c_stIssue) && (r_winner == 2'(gi));
        // A same-edge issue frees a slot, so a full counter only saturates without one.
        assign w_sat[gi]    = w_event[gi] && !w_issue[gi] && (r_pend[gi] == c_pendMax);
    end

    assign w_grant = (r_state == c_stIdle) && Enable && !Deliver && (|w_pendNz);

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = '0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && w_pendNz[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_inD  <= '0;
            r_pend <= '0;
        end else begin
            r_inD <= w_coinIn;
            for (int k = 0; k < 4; k++) begin
                if (w_event[k] && !w_issue[k]) begin
                    if (r_pend[k] != c_pendMax) begin
                        r_pend[k] <= r_pend[k] + 1'b1;
                    end
                end else if (!w_event[k] && w_issue[k]) begin
                    r_pend[k] <= r_pend[k] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_stIdle;
            r_ptr     <= '0;
            r_winner  <= '0;
            r_gapCnt  <= '0;
            r_coinOut <= '0;
        end else begin
            r_coinOut <= '0;
            case (r_state)
                c_stIdle: begin
                    if (w_grant) begin
                        r_state   <= c_stIssue;
                        r_winner  <= w_winner;
                        r_ptr     <= w_winner + 2'd1;
                        r_coinOut <= 4'b0001 << w_winner;
                    end
                end
                c_stIssue: begin
                    r_state  <= c_stGap;
                    r_gapCnt <= c_gapLoad;
                end
                c_stGap: begin
                    if (r_gapCnt == '0) begin
                        r_state <= c_stIdle;
                    end else begin
                        r_gapCnt <= r_gapCnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_stIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overflow <= 1'b0;
        end else if (|w_sat) begin
            r_overflow <= 1'b1;
        end
    end

    assign OneDollar  = r_coinOut[0];
    assign FiftyCents = r_coinOut[1];
    assign TenCents   = r_coinOut[2];
    assign FiveCents  = r_coinOut[3];
    assign Busy       = (|w_pendNz) || (r_state != c_stIdle);
    assign Overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_coin_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_scheduler
// Purpose  : Directed scoreboard bench for coin_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_scheduler;

    logic CLK = 1'b0;
    logic RST, Enable, Deliver;
    logic OneDollarIn, FiftyCentsIn, TenCentsIn, FiveCentsIn;
    logic OneDollar, FiftyCents, TenCents, FiveCents, Busy, Overflow;

    coin_scheduler #(.PEND_W(3), .GAP_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .Enable(Enable),
        .OneDollarIn(OneDollarIn), .FiftyCentsIn(FiftyCentsIn),
        .TenCentsIn(TenCentsIn), .FiveCentsIn(FiveCentsIn),
        .Deliver(Deliver),
        .OneDollar(OneDollar), .FiftyCents(FiftyCents),
        .TenCents(TenCents), .FiveCents(FiveCents),
        .Busy(Busy), .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int coin;
        int at;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic prevPulse = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic pushExp(input int coin, input int at);
        exp_t e;
        e.coin = coin;
        e.at   = at;
        sbq.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic int coinVec();
        return int'({FiveCents, TenCents, FiftyCents, OneDollar});
    endfunction

    // Output monitor: every pulse must be one-hot, isolated and expected
    always @(negedge CLK) begin
        int   v;
        int   idx;
        exp_t e;
        v = coinVec();
        if (v != 0) begin
            check("onehot", $countones(v), 1);
            check("no_back_to_back", int'(prevPulse), 0);
            idx = 0;
            for (int b = 3; b >= 0; b--) if (v[b]) idx = b;
            check("pulse_expected", int'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("pulse_coin", idx, e.coin);
                if (e.at >= 0) check("pulse_cycle", cyc, e.at);
            end
        end
        prevPulse = (v != 0);
    end

    task automatic doReset();
        @(negedge CLK);
        RST = 1'b1;
        {OneDollarIn, FiftyCentsIn, TenCentsIn, FiveCentsIn} = '0;
        Deliver = 1'b0;
        Enable  = 1'b1;
        waitCycles(2);
        RST = 1'b0;
    endtask

    initial begin
        int c;
        RST = 1'b1; Enable = 1'b1; Deliver = 1'b0;
        {OneDollarIn, FiftyCentsIn, TenCentsIn, FiveCentsIn} = '0;

        // Reset state
        waitCycles(2);
        check("rst_coins", coinVec(), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_overflow", int'(Overflow), 0);
        RST = 1'b0;

        // Single coin, held level
        waitCycles(1);
        c = cyc;
        TenCentsIn = 1'b1;
        pushExp(2, c + 2);
        waitCycles(1);
        check("single_busy_up", int'(Busy), 1);
        waitCycles(19);
        check("single_busy_down", int'(Busy), 0);
        check("single_sb_empty", sbq.size(), 0);
        TenCentsIn = 1'b0;

        // Simultaneous insertion from pointer 0
        doReset();
        c = cyc;
        {OneDollarIn, FiftyCentsIn, TenCentsIn, FiveCentsIn} = 4'hF;
        for (int i = 0; i < 4; i++) pushExp(i, c + 2 + 4 * i);
        waitCycles(20);
        {OneDollarIn, FiftyCentsIn, TenCentsIn, FiveCentsIn} = '0;
        check("simul_sb_empty", sbq.size(), 0);
        check("simul_busy", int'(Busy), 0);

        // Round-robin fairness
        doReset();
        Deliver = 1'b1;
        for (int i = 0; i < 3; i++) begin
            OneDollarIn = 1'b1; FiveCentsIn = 1'b1;
            waitCycles(1);
            OneDollarIn = 1'b0; FiveCentsIn = 1'b0;
            waitCycles(1);
        end
        check("rr_no_pulse_while_deliver", sbq.size(), 0);
        c = cyc;
        Deliver = 1'b0;
        for (int i = 0; i < 6; i++) pushExp((i % 2 == 0) ? 0 : 3, c + 1 + 4 * i);
        waitCycles(30);
        check("rr_sb_empty", sbq.size(), 0);

        // Saturation
        doReset();
        Deliver = 1'b1;
        for (int i = 0; i < 8; i++) begin
            FiftyCentsIn = 1'b1;
            waitCycles(1);
            if (i == 6) check("sat_no_ovf_at_7", int'(Overflow), 0);
            if (i == 7) check("sat_ovf_at_8", int'(Overflow), 1);
            FiftyCentsIn = 1'b0;
            waitCycles(1);
        end
        c = cyc;
        Deliver = 1'b0;
        for (int i = 0; i < 7; i++) pushExp(1, c + 1 + 4 * i);
        waitCycles(36);
        check("sat_sb_empty", sbq.size(), 0);
        check("sat_ovf_sticky", int'(Overflow), 1);
        check("sat_busy", int'(Busy), 0);

        // Enable gating: edges while disabled are dropped
        doReset();
        Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            FiveCentsIn = 1'b1;
            waitCycles(1);
            FiveCentsIn = 1'b0;
            waitCycles(1);
        end
        check("en_busy", int'(Busy), 0);
        check("en_overflow", int'(Overflow), 0);
        Enable = 1'b1;
        waitCycles(10);
        check("en_busy_after", int'(Busy), 0);

        // Deliver gating with one queued coin
        Deliver = 1'b1;
        TenCentsIn = 1'b1;
        waitCycles(1);
        TenCentsIn = 1'b0;
        check("dlv_busy_queued", int'(Busy), 1);
        waitCycles(9);
        c = cyc;
        Deliver = 1'b0;
        pushExp(2, c + 1);
        waitCycles(10);
        check("dlv_sb_empty", sbq.size(), 0);

        // Reset during GAP with two coins pending
        doReset();
        c = cyc;
        {OneDollarIn, FiftyCentsIn, TenCentsIn} = 3'b111;
        pushExp(0, c + 2);
        waitCycles(3);
        check("mid_busy_in_gap", int'(Busy), 1);
        RST = 1'b1;
        {OneDollarIn, FiftyCentsIn, TenCentsIn} = 3'b000;
        waitCycles(1);
        check("mid_coins", coinVec(), 0);
        check("mid_busy", int'(Busy), 0);
        check("mid_overflow", int'(Overflow), 0);
        RST = 1'b0;
        waitCycles(15);
        check("mid_sb_empty", sbq.size(), 0);
        check("mid_busy_after", int'(Busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
